inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 29 ++
 rtl/inst_loader_byte_pack.sv | 41 ++++
 rtl/inst_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared definitions for the instruction loader.
//   - state_t        : loader FSM states (CSUM exists only when the checksum
//                      feature is built in)
//   - BYTE_W         : width of one stream byte
//   - DEFAULT_ADDR_W : default instruction-memory address width
// Build option: INST_LOADER_CHECKSUM_EN adds the CSUM state.
package inst_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_ADDR_W = 8;

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    FIN  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/inst_loader_byte_pack.sv
// byte_pack: assembles a little-endian byte stream into 16-bit words.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : forces the byte phase back to "low" (start of a new load)
//   xfer        : a byte transfers this cycle
//   data_byte   : the byte being transferred
//   word        : {current byte, latched low byte}; valid when word_valid=1
//   word_valid  : high in the cycle the high byte transfers
module byte_pack
  import inst_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  xfer,
  input  logic [BYTE_W-1:0]     data_byte,
  output logic [2*BYTE_W-1:0]   word,
  output logic                  word_valid
);

  logic              phase_reg;  // 0: expecting low byte, 1: expecting high byte
  logic [BYTE_W-1:0] low_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= 1'b0;
      low_reg   <= '0;
    end else if (clear) begin
      phase_reg <= 1'b0;
    end else if (xfer) begin
      if (!phase_reg) low_reg <= data_byte;
      phase_reg <= ~phase_reg;
    end
  end

  // The word is presented combinationally so the loader can register the
  // memory write on the very edge that takes the high byte.
  assign word       = {data_byte, low_reg};
  assign word_valid = xfer & phase_reg;

endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a byte stream (header word N, N data words, optional
// checksum trailer) into instruction memory while holding the CPU in reset.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a load (sampled in IDLE only)
//   in_valid/in_byte    : byte-stream source
//   in_ready            : loader takes in_byte this cycle
//   mem_we/mem_addr/
//   mem_wdata           : registered instruction-memory write port
//   cpu_hold            : keeps fetch/PC logic in reset during a load
//   busy                : load in progress
//   done                : one-cycle pulse at the end of every load
//   err                 : sticky error of the last load
// Build option: INST_LOADER_CHECKSUM_EN enables the 16-bit sum trailer check.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WORD_W = 16              // fixed at 16 in this revision
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so a full-memory load (N = 2**ADDR_W) is representable.
  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
  localparam logic [31:0]       DEPTH = 32'd1 << ADDR_W;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    n_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WORD_W-1:0]   mem_wdata_reg;
  logic                err_reg;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [15:0]         sum_reg;
`endif

  logic                xfer;
  logic                load_start;
  logic [15:0]         word;
  logic                word_valid;
  logic                hdr_zero;
  logic                hdr_big;
  logic                last_word;

  assign xfer       = in_valid & in_ready;
  assign load_start = (state_reg == IDLE) & start;
  assign hdr_zero   = (word == 16'd0);
  assign hdr_big    = (32'(word) > DEPTH);
  assign last_word  = ((count_reg + ONE) == n_reg);

  byte_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .xfer       (xfer),
    .data_byte  (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Moore-style status outputs, decoded from the state register only so that
  // in_ready never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    case (state_reg)
      HDR, DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
`endif
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = HDR;
      HDR: begin
        if (word_valid) state_next = (hdr_zero || hdr_big) ? FIN : DATA;
      end
      DATA: begin
        if (word_valid && last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = FIN;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: if (word_valid) state_next = FIN;
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counter, header latch, registered write port, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      n_reg         <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      mem_we_reg <= 1'b0;
      if (load_start) begin
        err_reg   <= 1'b0;
        count_reg <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_reg   <= '0;
`endif
      end
      if (word_valid) begin
        case (state_reg)
          HDR: begin
            if (hdr_big) err_reg <= 1'b1;
            else         n_reg   <= CNT_W'(word);
          end
          DATA: begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= count_reg[ADDR_W-1:0];
            mem_wdata_reg <= WORD_W'(word);
            count_reg     <= count_reg + ONE;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_reg       <= sum_reg + word;
`endif
          end
`ifdef INST_LOADER_CHECKSUM_EN
          CSUM: if (word != sum_reg) err_reg <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign err       = err_reg;

endmodule
